neuron_mac_stream: RTL

Next-generation single neuron for the MNIST fully-connected layers. It consumes LANES (input, weight) pairs per beat through a valid/ready stream and accumulates the full dot product. It then adds a per-neuron bias, rescales, saturates and optionally applies ReLU. The result is presented on a valid/ready output. This replaces the externally counter-driven, one-product-per-cycle neuron with a self-sequenced, multi-lane, back-pressurable one.

---
 rtl/neuron_pkg.sv | 58 +++++
 rtl/neuron_lane_tree.sv | 66 ++++++
 rtl/neuron_mac_stream.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// neuron_pkg
// Shared state encoding and arithmetic helpers for neuron_mac_stream.
// Revision: 1.0
// ============================================================================
package neuron_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        DRAIN  = 3'd2,
        FINISH = 3'd3,
        OUT    = 3'd4
    } state_t;

    localparam int c_max_lanes = 16;

    // LANES is a power of two, so the ceiling divide reduces to a shift.
    function automatic int beats_for(input int n_inputs, input int lanes);
        return (n_inputs + lanes - 1) >> $clog2(lanes);
    endfunction

    function automatic logic [c_max_lanes-1:0] last_beat_mask(input int n_inputs, input int lanes);
        int                     live;
        logic [c_max_lanes-1:0] mask;
        live = n_inputs - ((beats_for(n_inputs, lanes) - 1) << $clog2(lanes));
        mask = '0;
        for (int i = 0; i < c_max_lanes; i++) begin
            mask[i] = (i < live);
        end
        return mask;
    endfunction

    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] value, input int bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    function automatic logic sat_hit(input logic signed [63:0] value, input int bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        return (value > hi) || (value < lo);
    endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_lane_tree.sv
`default_nettype none
// ============================================================================
// neuron_lane_tree
// Registered LANES-wide signed multiply feeding a balanced combinational adder tree.
// Revision: 1.0
// ============================================================================
module neuron_lane_tree #(
    parameter int LANES     = 4,
    parameter int DATA_BITS = 9,
    parameter int W_BITS    = 16,
    parameter int SUM_BITS  = 27
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en,
    input  logic [LANES*DATA_BITS-1:0]   data,
    input  logic [LANES*W_BITS-1:0]      weight,
    input  logic [LANES-1:0]             lane_mask,
    output logic signed [SUM_BITS-1:0]   sum,
    output logic                         sum_valid
);
    localparam int c_prod_bits = DATA_BITS + W_BITS;

    logic signed [c_prod_bits-1:0] w_prod [LANES];
    logic signed [c_prod_bits-1:0] r_prod [LANES];
    logic signed [SUM_BITS-1:0]    w_node [2*LANES-1];
    logic                          r_valid;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_prod[l] = c_prod_bits'($signed(data[l*DATA_BITS +: DATA_BITS]))
                      * c_prod_bits'($signed(weight[l*W_BITS +: W_BITS]));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int l = 0; l < LANES; l++) begin
                r_prod[l] <= '0;
            end
            r_valid <= 1'b0;
        end else begin
            r_valid <= en;
            if (en) begin
                for (int l = 0; l < LANES; l++) begin
                    r_prod[l] <= lane_mask[l] ? w_prod[l] : '0;
                end
            end
        end
    end

    // Heap-ordered tree: leaves sit at LANES-1.., node i sums children 2i+1 and 2i+2.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_node[LANES-1+l] = SUM_BITS'(r_prod[l]);
        end
        for (int i = LANES - 2; i >= 0; i--) begin
            w_node[i] = w_node[2*i+1] + w_node[2*i+2];
        end
    end

    assign sum       = w_node[0];
    assign sum_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/neuron_mac_stream.sv
`default_nettype none
// ============================================================================
// neuron_mac_stream
// Self-sequenced multi-lane neuron: streamed dot product, bias, rescale, saturate, ReLU.
// Revision: 1.0
// ============================================================================
module neuron_mac_stream
    import neuron_pkg::*;
#(
    parameter int N_INPUTS   = 784,
    parameter int LANES      = 4,
    parameter int DATA_BITS  = 9,
    parameter int W_BITS     = 16,
    parameter int B_BITS     = 24,
    parameter int ACC_BITS   = 48,
    parameter int FRAC_SHIFT = 8,
    parameter int OUT_BITS   = 17
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic                         act_en,
    input  logic signed [B_BITS-1:0]     bias,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*DATA_BITS-1:0]   in_data,
    input  logic [LANES*W_BITS-1:0]      in_weight,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_BITS-1:0]   out_data,
    output logic                         out_sat,
    output logic                         busy
);
    localparam int c_beats    = beats_for(N_INPUTS, LANES);
    localparam int c_cnt_bits = $clog2(c_beats + 1);
    localparam int c_sum_bits = DATA_BITS + W_BITS + $clog2(LANES);
    localparam int c_ext_bits = ACC_BITS + 1;
    localparam logic [c_max_lanes-1:0] c_last_mask = last_beat_mask(N_INPUTS, LANES);
    localparam logic [c_cnt_bits-1:0]  c_last_beat = c_cnt_bits'(c_beats - 1);

    if ((LANES < 1) || (LANES > c_max_lanes) || ((LANES & (LANES - 1)) != 0) || (N_INPUTS < 1)
        || (ACC_BITS < DATA_BITS + W_BITS + $clog2(N_INPUTS) + 1) || (ACC_BITS > 62)
        || (c_sum_bits > ACC_BITS) || (OUT_BITS < 2) || (OUT_BITS > 63)) begin : g_param_check
        $error("neuron_mac_stream: illegal parameter combination");
    end

    state_t                          r_state;
    state_t                          w_state_nx;
    logic [c_cnt_bits-1:0]           r_beat;
    logic                            r_drain;
    logic                            r_act;
    logic signed [B_BITS-1:0]        r_bias;
    logic signed [ACC_BITS-1:0]      r_acc;
    logic                            w_accept;
    logic                            w_last;
    logic [LANES-1:0]                w_mask;
    logic signed [c_sum_bits-1:0]    w_tree_sum;
    logic                            w_tree_valid;
    logic signed [c_ext_bits-1:0]    w_biased;
    logic signed [c_ext_bits-1:0]    w_shifted;
    logic signed [63:0]              w_wide;
    logic signed [63:0]              w_clip;
    logic                            w_clipped;

    assign in_ready = (r_state == ACCUM);
    assign busy     = (r_state != IDLE);
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_beat == c_last_beat);
    assign w_mask   = w_last ? c_last_mask[LANES-1:0] : {LANES{1'b1}};

    neuron_lane_tree #(
        .LANES     (LANES),
        .DATA_BITS (DATA_BITS),
        .W_BITS    (W_BITS),
        .SUM_BITS  (c_sum_bits)
    ) u_lane_tree (
        .clk       (clk),
        .rstn      (rstn),
        .en        (w_accept),
        .data      (in_data),
        .weight    (in_weight),
        .lane_mask (w_mask),
        .sum       (w_tree_sum),
        .sum_valid (w_tree_valid)
    );

    // One extra bit so the bias add cannot wrap before the shift and clip.
    assign w_biased  = c_ext_bits'(r_acc) + c_ext_bits'(r_bias);
    assign w_shifted = w_biased >>> FRAC_SHIFT;
    assign w_wide    = 64'(w_shifted);
    assign w_clip    = sat_clip(w_wide, OUT_BITS);
    assign w_clipped = sat_hit(w_wide, OUT_BITS);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nx = ACCUM;
            ACCUM:   if (w_accept && w_last) w_state_nx = DRAIN;
            DRAIN:   if (r_drain) w_state_nx = FINISH;
            FINISH:  w_state_nx = OUT;
            OUT:     if (out_ready) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beat    <= '0;
            r_drain   <= 1'b0;
            r_act     <= 1'b0;
            r_bias    <= '0;
            r_acc     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_beat <= '0;
                        r_acc  <= '0;
                        r_bias <= bias;
                        r_act  <= act_en;
                    end
                end
                ACCUM: begin
                    if (w_accept) r_beat <= r_beat + 1'b1;
                end
                DRAIN: begin
                    r_drain <= ~r_drain;
                end
                FINISH: begin
                    out_data  <= (r_act && (w_clip < 0)) ? '0 : OUT_BITS'(w_clip);
                    out_sat   <= w_clipped;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
            if (w_tree_valid) begin
                r_acc <= r_acc + ACC_BITS'(w_tree_sum);
            end
        end
    end

endmodule
`default_nettype wire
